lsu_mem_ctrl: RTL and testbench



---
 rtl/lsu_mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store sequencer in front of data_memory.
// A request is latched in IDLE, drives one ACCESS cycle of memory strobes,
// then waits in RESP until the consumer takes the response.
// Optional build macro: LSU_BOUNDS_CHECK_EN. When defined, requests at or
// above LIMIT_ADDR are faulted: no memory strobe, resp_fault=1, rdata=0 and
// no counter increment.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8,
  parameter logic [ADDR_W-1:0] LIMIT_ADDR = 8'hF0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count
);

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              fault_q;
  logic              req_fault;
  logic              accept;
  logic              resp_done;

  // Saturating increment: the debug counters stick at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // A request is rejected only when the bounds check is compiled in.
  assign req_fault = BOUNDS_EN && (req_addr >= LIMIT_ADDR);

  assign accept    = (state_q == IDLE) && req_valid;
  assign resp_done = (state_q == RESP) && resp_ready;

  // The memory address and write data come straight from the request latch,
  // so they hold their last value once ACCESS is over.
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake/strobe outputs; strobes are decoded from the
  // state register so an asynchronous reset drops them immediately.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_d = ACCESS;
      end
      ACCESS: begin
        mem_write = we_q & ~fault_q;
        mem_read  = ~we_q & ~fault_q;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Request latch: captured only on acceptance in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      fault_q <= req_fault;
    end
  end

  // Response capture on the edge leaving ACCESS; held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else if (state_q == ACCESS) begin
      resp_rdata <= (!we_q && !fault_q) ? mem_read_data : '0;
      resp_fault <= fault_q;
    end
  end

  // Completed-access counters bump on the response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_count  <= '0;
      store_count <= '0;
    end else if (resp_done && !fault_q) begin
      if (we_q) store_count <= sat_inc(store_count);
      else      load_count  <= sat_inc(load_count);
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: data_memory stand-in plus a transaction-level
// reference model (plain array and saturating integer counts).
module tb_lsu_mem_ctrl;
  localparam logic [7:0] LIMIT = 8'hF0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
  logic       req_ready, resp_valid, resp_fault, mem_write, mem_read, busy;
  logic [7:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
  logic [7:0] load_count, store_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] env_mem [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256];
  int ref_loads, ref_stores;

  lsu_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .CNT_W(8), .LIMIT_ADDR(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data),
    .busy(busy), .load_count(load_count), .store_count(store_count)
  );

  always #5 clk = ~clk;

  // data_memory stand-in: synchronous write, combinational read gated by mem_read.
  always @(posedge clk) if (mem_write) env_mem[mem_address] <= mem_write_data;
  assign mem_read_data = mem_read ? env_mem[mem_address] : 8'h00;

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, want finish before 2ms");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic bit exp_fault(input logic [7:0] a);
`ifdef LSU_BOUNDS_CHECK_EN
    return a >= LIMIT;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] exp_rdata(input logic we, input logic [7:0] a);
    if (we || exp_fault(a)) return 8'h00;
    return ref_mem[a];
  endfunction

  task automatic model_commit(input logic we, input logic [7:0] a, input logic [7:0] d);
    if (exp_fault(a)) return;
    if (we) begin
      ref_mem[a] = d;
      ref_stores = (ref_stores >= 255) ? 255 : ref_stores + 1;
    end else begin
      ref_loads = (ref_loads >= 255) ? 255 : ref_loads + 1;
    end
  endtask

  // ---------------- transaction driver (no checking) ----------------
  task automatic drive_txn(input logic we, input logic [7:0] a, input logic [7:0] d,
                           input int stall, output logic [7:0] rdata, output logic fault,
                           output int n_wr, output int n_rd, output int lat,
                           output bit bad_addr, output bit unstable, output bit timeout);
    int guard;
    n_wr = 0; n_rd = 0; lat = 0; bad_addr = 0; unstable = 0; timeout = 0;
    rdata = 8'h00; fault = 1'b0;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!req_ready) begin timeout = 1; return; end
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
    guard = 0;
    while (!resp_valid && guard < 20) begin
      if (mem_write) n_wr++;
      if (mem_read) n_rd++;
      if ((mem_write || mem_read) && mem_address !== a) bad_addr = 1;
      if (mem_write && mem_write_data !== d) bad_addr = 1;
      lat++;
      @(negedge clk);
      guard++;
    end
    if (!resp_valid) begin timeout = 1; return; end
    rdata = resp_rdata; fault = resp_fault;
    for (int i = 0; i < stall; i++) begin
      if (!resp_valid || resp_rdata !== rdata || resp_fault !== fault ||
          req_ready || mem_write || mem_read) unstable = 1;
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b busy=%b rv=%b want 1 0 0", req_ready, busy, resp_valid);
    end
    checks++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0 || resp_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: got wr=%b rd=%b flt=%b want 0 0 0", mem_write, mem_read, resp_fault);
    end
    checks++;
    if ({resp_rdata, mem_address, mem_write_data, load_count, store_count} !== 40'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h %h want all 0",
               resp_rdata, mem_address, mem_write_data, load_count, store_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_store_load;
    logic [7:0] rd; logic flt; int nw, nr, lat; bit ba, us, to;
    drive_txn(1'b1, 8'h10, 8'hBB, 0, rd, flt, nw, nr, lat, ba, us, to);
    model_commit(1'b1, 8'h10, 8'hBB);
    checks++;
    if (to || nw !== 1 || nr !== 0 || ba || lat !== 1) begin
      errors++;
      $display("FAIL store_10_strobe: got to=%0d wr=%0d rd=%0d badaddr=%0d lat=%0d want 0 1 0 0 1",
               to, nw, nr, ba, lat);
    end
    checks++;
    if (rd !== 8'h00 || flt !== 1'b0 || store_count !== 8'd1) begin
      errors++;
      $display("FAIL store_10_resp: got rdata=%h flt=%b cnt=%0d want 00 0 1", rd, flt, store_count);
    end
    drive_txn(1'b0, 8'h10, 8'h00, 0, rd, flt, nw, nr, lat, ba, us, to);
    model_commit(1'b0, 8'h10, 8'h00);
    checks++;
    if (to || nw !== 0 || nr !== 1 || ba || lat !== 1) begin
      errors++;
      $display("FAIL load_10_strobe: got to=%0d wr=%0d rd=%0d badaddr=%0d lat=%0d want 0 0 1 0 1",
               to, nw, nr, ba, lat);
    end
    checks++;
    if (rd !== 8'hBB || load_count !== 8'd1) begin
      errors++;
      $display("FAIL load_10_resp: got rdata=%h cnt=%0d want bb 1", rd, load_count);
    end
    drive_txn(1'b0, 8'h01, 8'h00, 0, rd, flt, nw, nr, lat, ba, us, to);
    model_commit(1'b0, 8'h01, 8'h00);
    checks++;
    if (to || rd !== 8'h00 || load_count !== 8'd2) begin
      errors++;
      $display("FAIL load_01_unwritten: got rdata=%h cnt=%0d want 00 2", rd, load_count);
    end
  endtask

  task automatic test_backpressure;
    bit held_bad = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_wdata = 8'h00; resp_ready = 1'b0;
    @(negedge clk);
    // Second request presented while the first is in flight.
    req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'h77;
    checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 8'h10) begin
      errors++;
      $display("FAIL bp_access: got rd=%b wr=%b addr=%h want 1 0 10", mem_read, mem_write, mem_address);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (resp_valid !== 1'b1 || resp_rdata !== 8'hBB || req_ready !== 1'b0 ||
          mem_write !== 1'b0 || busy !== 1'b1) held_bad = 1;
      @(negedge clk);
    end
    checks++;
    if (held_bad) begin
      errors++;
      $display("FAIL bp_hold: got unstable response window, want resp_valid=1 rdata=bb req_ready=0");
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    model_commit(1'b0, 8'h10, 8'h00);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0 ||
        load_count !== 8'(ref_loads)) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b rv=%b busy=%b lcnt=%0d want 1 0 0 %0d",
               req_ready, resp_valid, busy, load_count, ref_loads);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_write !== 1'b1 || mem_address !== 8'h20 || mem_write_data !== 8'h77) begin
      errors++;
      $display("FAIL bp_second_accept: got wr=%b addr=%h wd=%h want 1 20 77",
               mem_write, mem_address, mem_write_data);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    model_commit(1'b1, 8'h20, 8'h77);
  endtask

  task automatic test_boundary;
    logic [7:0] rd; logic flt; int nw, nr, lat; bit ba, us, to;
    drive_txn(1'b1, 8'hFF, 8'hCC, 0, rd, flt, nw, nr, lat, ba, us, to);
    model_commit(1'b1, 8'hFF, 8'hCC);
    drive_txn(1'b0, 8'hFF, 8'h00, 1, rd, flt, nw, nr, lat, ba, us, to);
    checks++;
    if (to || rd !== (exp_fault(8'hFF) ? 8'h00 : 8'hCC) || flt !== exp_fault(8'hFF)) begin
      errors++;
      $display("FAIL load_ff: got rdata=%h flt=%b want %h %b",
               rd, flt, exp_fault(8'hFF) ? 8'h00 : 8'hCC, exp_fault(8'hFF));
    end
    model_commit(1'b0, 8'hFF, 8'h00);
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a, d;
      a = 8'($urandom); d = 8'($urandom);
      drive_txn(1'b1, a, d, 0, rd, flt, nw, nr, lat, ba, us, to);
      model_commit(1'b1, a, d);
      if (to) break;
    end
    checks++;
    if (store_count !== 8'(ref_stores) || ref_stores != 255) begin
      errors++;
      $display("FAIL store_saturate: got %0d want %0d (model %0d)", store_count, 255, ref_stores);
    end
    checks++;
    if (load_count !== 8'(ref_loads)) begin
      errors++;
      $display("FAIL load_count_after_stores: got %0d want %0d", load_count, ref_loads);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] rd; logic flt; int nw, nr, lat; bit ba, us, to;
    drive_txn(1'b1, 8'h00, 8'hAA, 0, rd, flt, nw, nr, lat, ba, us, to);
    model_commit(1'b1, 8'h00, 8'hAA);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h00; req_wdata = 8'hDD;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_write !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_in_access: got wr=%b want 1", mem_write);
    end
    rst_n = 1'b0;
    #1;
    ref_loads = 0; ref_stores = 0;
    checks++;
    if (mem_write !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ctrl: got wr=%b busy=%b rdy=%b rv=%b want 0 0 1 0",
               mem_write, busy, req_ready, resp_valid);
    end
    checks++;
    if ({mem_address, mem_write_data, resp_rdata, load_count, store_count} !== 40'h0) begin
      errors++;
      $display("FAIL rstmid_data: got %h %h %h %h %h want all 0",
               mem_address, mem_write_data, resp_rdata, load_count, store_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_txn(1'b0, 8'h00, 8'h00, 0, rd, flt, nw, nr, lat, ba, us, to);
    model_commit(1'b0, 8'h00, 8'h00);
    checks++;
    if (to || rd !== 8'hAA || load_count !== 8'd1) begin
      errors++;
      $display("FAIL rstmid_no_commit: got rdata=%h cnt=%0d want aa 1", rd, load_count);
    end
  endtask

  task automatic test_fault;
    logic [7:0] rd; logic flt; int nw, nr, lat; bit ba, us, to;
    int sc_before;
    sc_before = ref_stores;
    drive_txn(1'b1, 8'hF5, 8'h11, 0, rd, flt, nw, nr, lat, ba, us, to);
    model_commit(1'b1, 8'hF5, 8'h11);
    checks++;
    if (to || flt !== exp_fault(8'hF5) || nw !== (exp_fault(8'hF5) ? 0 : 1) || rd !== 8'h00) begin
      errors++;
      $display("FAIL fault_store_f5: got flt=%b wr=%0d rdata=%h want %b %0d 00",
               flt, nw, rd, exp_fault(8'hF5), exp_fault(8'hF5) ? 0 : 1);
    end
    checks++;
    if (store_count !== 8'(ref_stores) || (exp_fault(8'hF5) && ref_stores != sc_before)) begin
      errors++;
      $display("FAIL fault_store_count: got %0d want %0d", store_count, ref_stores);
    end
    drive_txn(1'b0, 8'hEF, 8'h00, 0, rd, flt, nw, nr, lat, ba, us, to);
    checks++;
    if (to || flt !== 1'b0 || nr !== 1 || rd !== exp_rdata(1'b0, 8'hEF)) begin
      errors++;
      $display("FAIL fault_load_ef: got flt=%b rd=%0d rdata=%h want 0 1 %h",
               flt, nr, rd, exp_rdata(1'b0, 8'hEF));
    end
    model_commit(1'b0, 8'hEF, 8'h00);
  endtask

  task automatic test_random;
    logic [7:0] rd; logic flt; int nw, nr, lat; bit ba, us, to;
    int bad = 0;
    for (int i = 0; i < 80; i++) begin
      logic we; logic [7:0] a, d; int st;
      logic [7:0] er; bit ef;
      we = 1'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'hE8, 8'hFF)) : 8'($urandom);
      d  = 8'($urandom);
      st = $urandom_range(0, 3);
      er = exp_rdata(we, a);
      ef = exp_fault(a);
      drive_txn(we, a, d, st, rd, flt, nw, nr, lat, ba, us, to);
      model_commit(we, a, d);
      checks++;
      if (to || rd !== er || flt !== ef || us || ba || lat !== 1 ||
          nw !== ((we && !ef) ? 1 : 0) || nr !== ((!we && !ef) ? 1 : 0) ||
          load_count !== 8'(ref_loads) || store_count !== 8'(ref_stores)) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("FAIL random_txn[%0d] we=%b a=%h: got rd=%h flt=%b wr=%0d rdn=%0d lc=%0d sc=%0d want rd=%h flt=%b lc=%0d sc=%0d",
                   i, we, a, rd, flt, nw, nr, load_count, store_count, er, ef, ref_loads, ref_stores);
      end
      if (to) break;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_loads = 0;
    ref_stores = 0;
    test_reset();
    test_store_load();
    test_backpressure();
    test_boundary();
    test_reset_mid();
    test_fault();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
